// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control / iterative multiplier block.
// The decode function is the single source of truth for ALUOp/funct mapping.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_OR    = 2'b10;
    localparam logic [1:0] ALUOP_RTYPE = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       illegal;
    } dec_t;

    // Unsupported R-type functs fall back to ADD so the ALU never sees a held code.
    function automatic dec_t alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
        dec_t d;
        d.ctrl    = CTRL_ADD;
        d.illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: d.ctrl = CTRL_ADD;
            ALUOP_SUB: d.ctrl = CTRL_SUB;
            ALUOP_OR:  d.ctrl = CTRL_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: d.ctrl = CTRL_ADD;
                    FUNCT_SUB: d.ctrl = CTRL_SUB;
                    FUNCT_AND: d.ctrl = CTRL_AND;
                    FUNCT_OR:  d.ctrl = CTRL_OR;
                    FUNCT_SLT: d.ctrl = CTRL_SLT;
                    FUNCT_MUL: d.ctrl = CTRL_MUL;
                    default: begin
                        d.ctrl    = CTRL_ADD;
                        d.illegal = 1'b1;
                    end
                endcase
            end
            default: d.ctrl = CTRL_ADD;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_ctrl_mul_if.sv
// EX-stage bundle between the pipeline (master) and the ALU control block (slave).
interface alu_ctrl_mul_if #(
    parameter int DATA_W = 32
);
    logic              valid_i;
    logic              flush_i;
    logic [5:0]        funct_i;
    logic [1:0]        ALUOp_i;
    logic [DATA_W-1:0] rs_data_i;
    logic [DATA_W-1:0] rt_data_i;
    logic [3:0]        ALUCtrl_o;
    logic              illegal_o;
    logic              mul_busy_o;
    logic              mul_done_o;
    logic [DATA_W-1:0] mul_result_o;

    modport master (
        output valid_i, flush_i, funct_i, ALUOp_i, rs_data_i, rt_data_i,
        input  ALUCtrl_o, illegal_o, mul_busy_o, mul_done_o, mul_result_o
    );

    modport slave (
        input  valid_i, flush_i, funct_i, ALUOp_i, rs_data_i, rt_data_i,
        output ALUCtrl_o, illegal_o, mul_busy_o, mul_done_o, mul_result_o
    );
endinterface

// File: rtl/mul_iter.sv
// Shift-add multiplier datapath retiring BPC multiplier bits per step.
// done_o is evaluated on the post-step values so the FSM can leave RUN on that edge.
module mul_iter #(
    parameter int DATA_W     = 32,
    parameter int BPC        = 1,
    parameter int EARLY_TERM = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] mcand_i,
    input  logic [DATA_W-1:0] mplier_i,
    output logic [DATA_W-1:0] acc_next_o,
    output logic              done_o
);
    localparam int   N        = DATA_W / BPC;
    localparam int   CNT_W    = $clog2(N + 1);
    localparam logic EARLY_EN = (EARLY_TERM != 32'sd0);

    logic [DATA_W-1:0] acc_q, mcand_q, mplier_q;
    logic [DATA_W-1:0] acc_d, mcand_d, mplier_d, pp_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next-step values: sum of BPC shifted partial products, then shift operands.
    always_comb begin
        pp_s = '0;
        for (int b = 0; b < BPC; b++) begin
            if (mplier_q[b]) begin
                pp_s = pp_s + (mcand_q << b);
            end else begin
                pp_s = pp_s;
            end
        end
        acc_d    = acc_q + pp_s;
        mcand_d  = mcand_q << BPC;
        mplier_d = mplier_q >> BPC;
        cnt_d    = cnt_q + CNT_W'(1);
    end

    assign acc_next_o = acc_d;
    assign done_o     = (cnt_d == CNT_W'(N)) || (EARLY_EN && (mplier_d == '0));

    // Operand/accumulator registers: load on start, advance on each RUN step.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end else begin
            acc_q    <= acc_q;
            mcand_q  <= mcand_q;
            mplier_q <= mplier_q;
            cnt_q    <= cnt_q;
        end
    end
endmodule

// File: rtl/alu_ctrl_mul.sv
// ALU control decode plus the IDLE/RUN/DONE sequencer for the iterative multiplier.
// Decode and the stall request are combinational; the product is registered.
module alu_ctrl_mul
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BPC        = 1,
    parameter int EARLY_TERM = 0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_ctrl_mul_if.slave  bus
);
    mul_state_e        state_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] acc_next_s;
    logic              iter_done_s;
    logic              is_mul_s;
    logic              start_s;
    logic              step_s;
    dec_t              dec_s;

    assign dec_s         = alu_decode(bus.ALUOp_i, bus.funct_i);
    assign bus.ALUCtrl_o = dec_s.ctrl;
    assign bus.illegal_o = dec_s.illegal;

    assign is_mul_s = (bus.ALUOp_i == ALUOP_RTYPE) && (bus.funct_i == FUNCT_MUL);
    assign start_s  = bus.valid_i && !bus.flush_i && is_mul_s && (state_q == ST_IDLE);
    assign step_s   = (state_q == ST_RUN) && !bus.flush_i;

    // Stall is held low while reset is asserted even though start is combinational.
    assign bus.mul_busy_o   = rst_i && (start_s || (state_q == ST_RUN));
    assign bus.mul_done_o   = (state_q == ST_DONE);
    assign bus.mul_result_o = result_q;

    mul_iter #(
        .DATA_W     (DATA_W),
        .BPC        (BPC),
        .EARLY_TERM (EARLY_TERM)
    ) u_mul_iter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (start_s),
        .step_i     (step_s),
        .mcand_i    (bus.rs_data_i),
        .mplier_i   (bus.rt_data_i),
        .acc_next_o (acc_next_s),
        .done_o     (iter_done_s)
    );

    // Sequencer; DONE always returns to IDLE so a held mul cannot restart itself.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.flush_i) begin
                        state_q <= ST_IDLE;
                    end else if (iter_done_s) begin
                        state_q  <= ST_DONE;
                        result_q <= acc_next_s;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl_mul.sv
// Bench: three configurations (BPC1, BPC4, BPC1+early exit) share one stimulus stream.
module tb_alu_ctrl_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  valid_r;
    logic        flush_r;
    logic [5:0]  funct_r;
    logic [1:0]  aluop_r;
    logic [31:0] rs_r, rt_r;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_res [3];

    alu_ctrl_mul_if #(.DATA_W(32)) bus0 ();
    alu_ctrl_mul_if #(.DATA_W(32)) bus1 ();
    alu_ctrl_mul_if #(.DATA_W(32)) bus2 ();

    assign bus0.valid_i = valid_r[0];
    assign bus1.valid_i = valid_r[1];
    assign bus2.valid_i = valid_r[2];
    assign bus0.flush_i = flush_r;
    assign bus1.flush_i = flush_r;
    assign bus2.flush_i = flush_r;
    assign bus0.funct_i = funct_r;
    assign bus1.funct_i = funct_r;
    assign bus2.funct_i = funct_r;
    assign bus0.ALUOp_i = aluop_r;
    assign bus1.ALUOp_i = aluop_r;
    assign bus2.ALUOp_i = aluop_r;
    assign bus0.rs_data_i = rs_r;
    assign bus1.rs_data_i = rs_r;
    assign bus2.rs_data_i = rs_r;
    assign bus0.rt_data_i = rt_r;
    assign bus1.rt_data_i = rt_r;
    assign bus2.rt_data_i = rt_r;

    alu_ctrl_mul #(.DATA_W(32), .BPC(1), .EARLY_TERM(0)) dut0 (.clk_i(clk), .rst_i(rst_n), .bus(bus0));
    alu_ctrl_mul #(.DATA_W(32), .BPC(4), .EARLY_TERM(0)) dut1 (.clk_i(clk), .rst_i(rst_n), .bus(bus1));
    alu_ctrl_mul #(.DATA_W(32), .BPC(1), .EARLY_TERM(1)) dut2 (.clk_i(clk), .rst_i(rst_n), .bus(bus2));

    logic [2:0]  busy_s, done_s;
    logic [31:0] res_s [3];
    assign busy_s   = {bus2.mul_busy_o, bus1.mul_busy_o, bus0.mul_busy_o};
    assign done_s   = {bus2.mul_done_o, bus1.mul_done_o, bus0.mul_done_o};
    assign res_s[0] = bus0.mul_result_o;
    assign res_s[1] = bus1.mul_result_o;
    assign res_s[2] = bus2.mul_result_o;

    typedef struct {
        logic [1:0] aluop;
        logic [5:0] funct;
        logic [3:0] ctrl;
        logic       ill;
    } dvec_t;

    dvec_t dtab [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode written from the opcode table.
    function automatic logic [4:0] ref_decode(input logic [1:0] aluop, input logic [5:0] funct);
        if (aluop == 2'b00) return {4'b0010, 1'b0};
        if (aluop == 2'b01) return {4'b0110, 1'b0};
        if (aluop == 2'b10) return {4'b0001, 1'b0};
        if (funct == 6'b100000) return {4'b0010, 1'b0};
        if (funct == 6'b100010) return {4'b0110, 1'b0};
        if (funct == 6'b100100) return {4'b0000, 1'b0};
        if (funct == 6'b100101) return {4'b0001, 1'b0};
        if (funct == 6'b101010) return {4'b0111, 1'b0};
        if (funct == 6'b011000) return {4'b1000, 1'b0};
        return {4'b0010, 1'b1};
    endfunction

    // Steps to completion: full width / BPC, or the digit length of the multiplier with early exit.
    function automatic int exp_steps(input int dut, input logic [31:0] rt);
        int bpc;
        int bl;
        int k;
        bpc = (dut == 1) ? 4 : 1;
        if (dut != 2) return 32 / bpc;
        bl = 0;
        for (int i = 0; i < 32; i++) if (rt[i]) bl = i + 1;
        k = (bl + bpc - 1) / bpc;
        return (k < 1) ? 1 : k;
    endfunction

    task automatic run_mul(input logic [31:0] rs, input logic [31:0] rt, input int flush_at, input string tag);
        int          ed [3];
        int          first_done [3];
        int          busy_cnt [3];
        int          done_cnt [3];
        logic [31:0] res_at_done [3];
        logic [31:0] prod;
        logic [2:0]  active;
        logic        flushed;
        prod = rs * rt;
        for (int i = 0; i < 3; i++) begin
            ed[i] = exp_steps(i, rt) + 1;
            first_done[i] = -1;
            busy_cnt[i] = 0;
            done_cnt[i] = 0;
            res_at_done[i] = 32'h0;
        end
        aluop_r = 2'b11;
        funct_r = 6'b011000;
        rs_r = rs;
        rt_r = rt;
        active = 3'b111;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            valid_r = active;
            flush_r = (cyc == flush_at);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (busy_s[i]) busy_cnt[i]++;
                if (done_s[i]) begin
                    done_cnt[i]++;
                    if (first_done[i] < 0) begin
                        first_done[i] = cyc;
                        res_at_done[i] = res_s[i];
                    end
                    active[i] = 1'b0;
                end
            end
            if (cyc == flush_at) active = 3'b000;
            // Operands move on while the multiply runs; the DUT must ignore them.
            if (cyc == 2) begin
                rs_r = ~rs;
                rt_r = rt ^ 32'h5A5A_A5A5;
            end
        end
        @(negedge clk);
        valid_r = 3'b000;
        flush_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flushed = (flush_at >= 1) && (flush_at < ed[i]);
            if (flushed) begin
                check($sformatf("%s/dut%0d/done_cnt", tag, i), done_cnt[i], 32'd0);
                check($sformatf("%s/dut%0d/busy_cnt", tag, i), busy_cnt[i], flush_at + 1);
                check($sformatf("%s/dut%0d/result_kept", tag, i), res_s[i], last_res[i]);
            end else begin
                check($sformatf("%s/dut%0d/done_cyc", tag, i), first_done[i], ed[i]);
                check($sformatf("%s/dut%0d/done_cnt", tag, i), done_cnt[i], 32'd1);
                check($sformatf("%s/dut%0d/busy_cnt", tag, i), busy_cnt[i], ed[i]);
                check($sformatf("%s/dut%0d/result", tag, i), res_at_done[i], prod);
                last_res[i] = prod;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [4:0]  ref_s;
        logic [31:0] rnd_rt;
        int          fa;

        rst_n   = 1'b0;
        valid_r = 3'b111;
        flush_r = 1'b0;
        aluop_r = 2'b11;
        funct_r = 6'b011000;
        rs_r    = 32'd7;
        rt_r    = 32'd6;
        for (int i = 0; i < 3; i++) last_res[i] = 32'h0;
        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset/dut%0d/busy", i), {31'd0, busy_s[i]}, 32'd0);
            check($sformatf("reset/dut%0d/done", i), {31'd0, done_s[i]}, 32'd0);
            check($sformatf("reset/dut%0d/result", i), res_s[i], 32'd0);
        end
        valid_r = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;

        dtab[0]  = '{2'b00, 6'b101010, 4'b0010, 1'b0};
        dtab[1]  = '{2'b01, 6'b111111, 4'b0110, 1'b0};
        dtab[2]  = '{2'b10, 6'b111111, 4'b0001, 1'b0};
        dtab[3]  = '{2'b10, 6'b100010, 4'b0001, 1'b0};
        dtab[4]  = '{2'b11, 6'b100000, 4'b0010, 1'b0};
        dtab[5]  = '{2'b11, 6'b100010, 4'b0110, 1'b0};
        dtab[6]  = '{2'b11, 6'b100100, 4'b0000, 1'b0};
        dtab[7]  = '{2'b11, 6'b100101, 4'b0001, 1'b0};
        dtab[8]  = '{2'b11, 6'b101010, 4'b0111, 1'b0};
        dtab[9]  = '{2'b11, 6'b011000, 4'b1000, 1'b0};
        dtab[10] = '{2'b11, 6'b111111, 4'b0010, 1'b1};
        dtab[11] = '{2'b11, 6'b000000, 4'b0010, 1'b1};
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            aluop_r = dtab[t].aluop;
            funct_r = dtab[t].funct;
            #1;
            check($sformatf("dec%0d/ctrl", t), {28'd0, bus0.ALUCtrl_o}, {28'd0, dtab[t].ctrl});
            check($sformatf("dec%0d/illegal", t), {31'd0, bus0.illegal_o}, {31'd0, dtab[t].ill});
            check($sformatf("dec%0d/busy_novalid", t), {31'd0, busy_s[0]}, 32'd0);
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            aluop_r = 2'($urandom_range(0, 3));
            funct_r = (t % 3 == 0) ? 6'b100010 : 6'($urandom_range(0, 63));
            #1;
            ref_s = ref_decode(aluop_r, funct_r);
            check($sformatf("rdec%0d/dut1", t), {27'd0, bus1.ALUCtrl_o, bus1.illegal_o}, {27'd0, ref_s});
        end

        run_mul(32'd7, 32'd6, -1, "mul7x6");
        run_mul(32'hFFFF_FFFD, 32'd5, -1, "mulneg");
        run_mul(32'h8000_0000, 32'd2, -1, "mulwrap");
        run_mul(32'd7, 32'd3, -1, "rt3");
        run_mul(32'd9, 32'd0, -1, "rt0");
        run_mul(32'd7, 32'h8000_0000, -1, "rtmsb");
        run_mul(32'd7, 32'd6, -1, "mul7x6b");
        run_mul(32'd11, 32'h0001_0000, 10, "flush10");
        run_mul(32'd13, 32'd17, -1, "afterflush");

        // Reset in the middle of RUN drops the product at once.
        aluop_r = 2'b11;
        funct_r = 6'b011000;
        rs_r = 32'd7;
        rt_r = 32'h0000_FFFF;
        for (int cyc = 0; cyc <= 5; cyc++) begin
            @(negedge clk);
            valid_r = (cyc == 0) ? 3'b111 : valid_r;
            if (cyc == 5) begin
                rst_n = 1'b0;
                #1;
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("midrst/dut%0d/busy", i), {31'd0, busy_s[i]}, 32'd0);
                    check($sformatf("midrst/dut%0d/done", i), {31'd0, done_s[i]}, 32'd0);
                    check($sformatf("midrst/dut%0d/result", i), res_s[i], 32'd0);
                    last_res[i] = 32'h0;
                end
            end
        end
        valid_r = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_mul(32'd3, 32'd4, -1, "post_rst");

        for (int t = 0; t < 6; t++) begin
            rnd_rt = $urandom >> $urandom_range(0, 31);
            fa = (t % 2 == 1) ? int'($urandom_range(1, 30)) : -1;
            run_mul($urandom, rnd_rt, fa, $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mul.md
# alu_ctrl_mul

ALU control unit with an integrated iterative multiplier for the EX stage of the pipelined MIPS core. It decodes ALUOp/funct into a 4-bit ALU control code. It also executes `mul` as a multi-cycle shift-add operation, driving a stall to the hazard unit until the product is ready. Unlike the single-cycle ALU control, every decode path is fully defined (no held values), `slt` is added, and illegal funct codes are flagged.

## Interface
- DATA_W, 32: operand/product width; must be a multiple of BPC.
- BPC, 1: multiplier bits retired per cycle (1, 2 or 4); N = DATA_W/BPC.
- EARLY_TERM, 0: 1 = finish as soon as the remaining multiplier bits are zero.

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- valid_i  in  1  EX stage holds a valid instruction
- flush_i  in  1  EX flush; aborts any multiply
- funct_i  in  6  R-type funct field
- ALUOp_i  in  2  from main control
- rs_data_i  in  DATA_W  multiplicand
- rt_data_i  in  DATA_W  multiplier
- ALUCtrl_o  out  4  ALU control code
- illegal_o  out  1  ALUOp=11 with an unsupported funct
- mul_busy_o  out  1  stall request
- mul_done_o  out  1  one-cycle pulse: product valid
- mul_result_o  out  DATA_W  last completed product

## Operation
- Decode is combinational:
  - ALUOp 00 → ADD 0010; 01 → SUB 0110; 10 → OR 0001.
  - ALUOp 11 decodes funct: 100000 ADD, 100010 SUB, 100100 AND 0000, 100101 OR, 101010 SLT 0111, 011000 MUL 1000.
  - ALUOp 11 with any other funct → ADD and illegal_o=1. illegal_o=0 in every other case.
- start = valid_i & !flush_i & ALUOp=11 & funct=011000 & state==IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start. On that edge, latch acc=0, mcand=rs_data_i, mplier=rt_data_i, count=0.
  - RUN: each edge adds the BPC partial products of mplier[BPC-1:0]×mcand into acc (mod 2^DATA_W), then shifts mcand left by BPC, shifts mplier right by BPC, and increments count.
  - RUN→DONE on the edge where count reaches N, or (EARLY_TERM and post-shift mplier==0). On that edge, mul_result_o←final acc.
  - DONE→IDLE unconditionally. start is masked in DONE, so the same instruction cannot restart.
  - flush_i in RUN or DONE → IDLE on the next edge. No done pulse; mul_result_o unchanged.
- The product is the low DATA_W bits, which are identical for signed and unsigned operands, so no sign handling is needed.
- mul_busy_o = start | (state==RUN). mul_done_o = (state==DONE).
- rs_data_i and rt_data_i changes during RUN are ignored.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, mul_result_o=0, mul_busy_o=0, mul_done_o=0, internal registers 0. mul_busy_o is forced 0 while rst_i is low.
- Reset mid-RUN aborts immediately; the product is lost.
- Decode outputs: zero latency.
- Multiply: start cycle c0 (busy combinational).
  - Without early exit: busy in cycles c0..cN, done and result valid in cN+1, pipeline advances in cN+1.
  - With early exit after k steps: busy c0..ck, done in ck+1, k≥1.
- Back-to-back `mul`: the next start is possible in the cycle after DONE.

## Structure
- Package alu_ctrl_pkg: ALUOp codes, funct codes, 4-bit ALUCtrl codes, FSM state enum.
- Sub-module mul_iter: acc/mcand/mplier/count datapath with a step enable and a done-condition output. alu_ctrl_mul holds the decode and the FSM.

## Test plan
- ALUOp 11, funct 100010 → ALUCtrl 0110, illegal 0. funct 101010 → 0111. funct 111111 → 0010, illegal 1. ALUOp 10 with any funct → 0001, illegal 0.
- DATA_W 32, BPC 1, EARLY_TERM 0, rs=7, rt=6, valid held → busy cycles c0–c32, done only in c33, result 42.
- rs=0xFFFFFFFD, rt=5 → 0xFFFFFFF1. rs=0x80000000, rt=2 → 0x00000000. BPC 4 with rs=7, rt=6 → done in c9, result 42.
- EARLY_TERM 1, BPC 1: rt=3 → done in c3. rt=0 → done in c2, result 0. rt=0x80000000 → done in c33.
- flush_i asserted in RUN at c10 → IDLE at c11, no done pulse, result still 42. Later mul completes normally.
- rst_i low at c5 of RUN → busy, done and result 0 immediately. After release, a new mul of 3×4 gives 12.
